acc_flag_unit: RTL

- 4-bit accumulator and status-flag register, directly downstream of the combinational 4-bit overflow-detecting adder `adder_vf`.
- Accepts an operation and operand through a start/busy/done handshake.
- Drives the adder operands, captures the adder sum `q` and overflow `VF` into the accumulator and the N/Z/V flags.
- Sequences SUB as two adder passes (negate, then add), because the adder has no carry-in.

---
 rtl/acc_flag_pkg.sv | 6 +
 rtl/acc_flag_unit_flag_gen.sv | 9 +
 rtl/adder_vf.sv | 10 +
 rtl/acc_flag_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/acc_flag_pkg.sv
// acc_flag_pkg: shared width, op codes and state encoding for the accumulator/flag unit
package acc_flag_pkg;
    localparam int W = 4;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, NEG = 2'b01, EXEC = 2'b10} state_t;
endpackage

// File: rtl/acc_flag_unit_flag_gen.sv
// flag_gen: negative and zero status of a W-bit value
module flag_gen #(parameter int W = 4) (
    input  logic [W-1:0] value,
    output logic         n,
    output logic         z
);
    assign n = value[W-1];
    assign z = (value == '0);
endmodule

// File: rtl/adder_vf.sv
// adder_vf: combinational 4-bit adder with signed-overflow flag and no carry-in
module adder_vf (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q,
    output logic       VF
);
    assign q  = a + b;
    assign VF = (a[3] == b[3]) && (q[3] != a[3]);
endmodule

// File: rtl/acc_flag_unit.sv
// acc_flag_unit: accumulator and N/Z/V flag register driving an external overflow-detecting adder
module acc_flag_unit #(parameter int W = acc_flag_pkg::W) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] opnd,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_v,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_q,
    input  logic         add_vf
);
    import acc_flag_pkg::*;

    state_t       state;
    op_t          op_r;
    logic [W-1:0] opnd_r;
    logic [W-1:0] tmp;
    logic         neg_ovf;
    logic [W-1:0] acc_nxt;
    logic         v_nxt;
    logic         n_nxt;
    logic         z_nxt;

    assign busy = (state != IDLE);

    // Adder operands: negate pass in NEG, accumulate pass in EXEC, acc+0 otherwise
    always_comb begin
        add_a = (state == NEG) ? ~opnd_r : acc;
        add_b = (state == NEG) ? W'(1) :
                (state == EXEC && op_r == OP_ADD) ? opnd_r :
                (state == EXEC && op_r == OP_SUB) ? tmp : '0;
    end

    // Result and overflow for the EXEC write; -MIN negation overflow is resolved from acc's sign
    always_comb begin
        acc_nxt = (op_r == OP_LOAD) ? opnd_r : (op_r == OP_CLR) ? '0 : add_q;
        v_nxt   = (op_r == OP_ADD) ? add_vf :
                  (op_r == OP_SUB) ? (neg_ovf ? ~acc[W-1] : add_vf) : 1'b0;
    end

    flag_gen #(.W(W)) u_flag_gen (
        .value (acc_nxt),
        .n     (n_nxt),
        .z     (z_nxt)
    );

    // Sequencer: accept in IDLE, optional negate pass, then commit acc/flags with a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= OP_LOAD;
            opnd_r  <= '0;
            tmp     <= '0;
            neg_ovf <= 1'b0;
            acc     <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b1;
            flag_v  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    op_r   <= op_t'(op);
                    opnd_r <= opnd;
                    state  <= (op_t'(op) == OP_SUB) ? NEG : EXEC;
                end
                NEG: begin
                    tmp     <= add_q;
                    neg_ovf <= add_vf;
                    state   <= EXEC;
                end
                EXEC: begin
                    acc    <= acc_nxt;
                    flag_n <= n_nxt;
                    flag_z <= z_nxt;
                    flag_v <= v_nxt;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
